// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse transmitter: frame/packet sizes,
// serialiser and packet-sequencer state encodings, and the 11-bit frame builder.
package ps2_pkg;

  localparam int FRAME_BITS = 11;
  localparam int PKT_BYTES  = 3;

  typedef logic [23:0] ps2_pkt_t;

  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP} ps2_state_t;

  typedef enum logic [1:0] {PKT_IDLE, PKT_SEND, PKT_GAP, PKT_HOLD} pkt_state_t;

  // Frame as sent on the wire, bit 0 first: start, data LSB first, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_frame_ser.sv
// Serialises one byte as an 11-bit PS/2 device frame (BIT_HI/BIT_LO half-periods)
// under a start/done handshake; aborts on host inhibit seen at the end of BIT_HI.
module ps2_frame_ser
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       inhibit,
  output logic       clk_out,
  output logic       dat_out,
  output logic       done,
  output logic       aborted
);

  localparam int HW = $clog2(HALF_PERIOD + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  ps2_state_t state, state_nxt;
  logic [HW-1:0] cnt, cnt_nxt;
  logic [3:0] bit_idx, bit_nxt;
  logic [FRAME_BITS-1:0] shift, shift_nxt, load;
  logic clk_nxt, dat_nxt, half_end;

  assign half_end = (cnt == HALF_LAST);
  assign load     = ps2_frame(data);

  // Outputs are registered, so a new data bit appears exactly in the first BIT_HI cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    clk_nxt   = clk_out;
    dat_nxt   = dat_out;
    done      = 1'b0;
    aborted   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) begin
          state_nxt = BIT_HI;
          shift_nxt = load;
          bit_nxt   = '0;
          dat_nxt   = load[0];
        end
      end
      BIT_HI: begin
        if (half_end) begin
          cnt_nxt = '0;
          if (inhibit && (bit_idx < LAST_BIT)) begin
            state_nxt = IDLE;
            aborted   = 1'b1;
            dat_nxt   = 1'b1;
          end else begin
            state_nxt = BIT_LO;
            clk_nxt   = 1'b0;
          end
        end
      end
      BIT_LO: begin
        if (half_end) begin
          cnt_nxt = '0;
          clk_nxt = 1'b1;
          if (bit_idx == LAST_BIT) begin
            state_nxt = IDLE;
            done      = 1'b1;
            dat_nxt   = 1'b1;
          end else begin
            state_nxt = BIT_HI;
            bit_nxt   = bit_idx + 1'b1;
            shift_nxt = {1'b1, shift[FRAME_BITS-1:1]};
            dat_nxt   = shift[1];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      clk_out <= 1'b1;
      dat_out <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      clk_out <= clk_nxt;
      dat_out <= dat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

endmodule

// File: rtl/ps2_mouse_tx.sv
// PS/2 mouse packet transmitter: strobe-toggle capture, one pending slot, byte sequencing
// and inter-byte gaps. Host inhibit handling is built when PS2_MOUSE_INHIBIT_EN is defined.
module ps2_mouse_tx
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 2000,
  parameter int BYTE_GAP    = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [24:0] ps2_mouse,
  input  logic        ps2_clk_in,
  output logic        ps2_clk_out,
  output logic        ps2_dat_out,
  output logic        busy,
  output logic        drop
);

  localparam int GAP_CYC = BYTE_GAP * HALF_PERIOD;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [1:0] LAST_BYTE = 2'(PKT_BYTES - 1);

  pkt_state_t state, state_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic [1:0] byte_idx, byte_nxt;
  logic strobe_ref, pend_vld, strobe, consume, start, line_low, gap_end;
  logic ser_done, ser_aborted;
  ps2_pkt_t pend_pkt, cur_pkt, src_pkt;
  logic [7:0] ser_data;

`ifdef PS2_MOUSE_INHIBIT_EN
  assign line_low = ~ps2_clk_in;
`else
  logic unused_clk_in;
  assign unused_clk_in = ps2_clk_in;
  assign line_low = 1'b0;
`endif

  assign strobe  = (ps2_mouse[24] != strobe_ref);
  assign gap_end = (gcnt == GAP_LAST);
  assign busy    = pend_vld || (state != PKT_IDLE);

  // A packet always passes through the pending slot; IDLE drains it on the next cycle.
  always_comb begin
    state_nxt = state;
    gcnt_nxt  = gcnt;
    byte_nxt  = byte_idx;
    consume   = 1'b0;
    start     = 1'b0;
    src_pkt   = cur_pkt;
    case (state)
      PKT_IDLE: begin
        if (pend_vld && !line_low) begin
          consume   = 1'b1;
          start     = 1'b1;
          src_pkt   = pend_pkt;
          byte_nxt  = '0;
          state_nxt = PKT_SEND;
        end
      end
      PKT_SEND: begin
        gcnt_nxt = '0;
        if (ser_done) state_nxt = PKT_GAP;
        else if (ser_aborted) state_nxt = PKT_HOLD;
      end
      PKT_GAP: begin
        gcnt_nxt = gcnt + 1'b1;
        if (gap_end) begin
          gcnt_nxt = '0;
          if (byte_idx != LAST_BYTE) begin
            byte_nxt  = byte_idx + 1'b1;
            start     = 1'b1;
            state_nxt = PKT_SEND;
          end else if (pend_vld) begin
            consume   = 1'b1;
            start     = 1'b1;
            src_pkt   = pend_pkt;
            byte_nxt  = '0;
            state_nxt = PKT_SEND;
          end else begin
            state_nxt = PKT_IDLE;
          end
        end
      end
      PKT_HOLD: begin
        if (line_low) begin
          gcnt_nxt = '0;
        end else if (gap_end) begin
          gcnt_nxt  = '0;
          byte_nxt  = '0;
          start     = 1'b1;
          state_nxt = PKT_SEND;
        end else begin
          gcnt_nxt = gcnt + 1'b1;
        end
      end
      default: state_nxt = PKT_IDLE;
    endcase
    case (byte_nxt)
      2'd0:    ser_data = src_pkt[7:0];
      2'd1:    ser_data = src_pkt[15:8];
      default: ser_data = src_pkt[23:16];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= PKT_IDLE;
      gcnt       <= '0;
      byte_idx   <= '0;
      pend_vld   <= 1'b0;
      drop       <= 1'b0;
      strobe_ref <= ps2_mouse[24];
    end else begin
      state      <= state_nxt;
      gcnt       <= gcnt_nxt;
      byte_idx   <= byte_nxt;
      strobe_ref <= ps2_mouse[24];
      drop       <= strobe && pend_vld && !consume;
      if (strobe) pend_vld <= 1'b1;
      else if (consume) pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (strobe) pend_pkt <= ps2_mouse[23:0];
    if (consume) cur_pkt <= pend_pkt;
  end

  ps2_frame_ser #(
    .HALF_PERIOD(HALF_PERIOD)
  ) frame_ser (
    .clk    (CLK),
    .reset_n(RESET_N),
    .start  (start),
    .data   (ser_data),
    .inhibit(line_low),
    .clk_out(ps2_clk_out),
    .dat_out(ps2_dat_out),
    .done   (ser_done),
    .aborted(ser_aborted)
  );

endmodule

// File: tb/tb_ps2_mouse_tx.sv
// Bench for ps2_mouse_tx: a line-level decoder rebuilds frames from the PS/2 pins and
// compares bytes against a queue of expected packet bytes.
module tb_ps2_mouse_tx;

  localparam int HP   = 4;
  localparam int BG   = 2;
  localparam int FLEN = 88;
  localparam int GAPC = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [24:0] ps2_mouse = '0;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_clk_out, ps2_dat_out, busy, drop;

  int checks = 0;
  int errors = 0;

  ps2_mouse_tx #(.HALF_PERIOD(HP), .BYTE_GAP(BG)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ps2_mouse  (ps2_mouse),
    .ps2_clk_in (ps2_clk_in),
    .ps2_clk_out(ps2_clk_out),
    .ps2_dat_out(ps2_dat_out),
    .busy       (busy),
    .drop       (drop)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: bytes the line must carry, in order
  logic [7:0] expq[$];
  int rx_byte[$], rx_par[$], gap_log[$];
  int starts = 0, frames = 0, aborts = 0, drops = 0;
  int bitcnt = 0, flen = 0, hi_run = 0, gap_cnt = 0;
  bit in_frame = 1'b0;
  logic prev_clk = 1'b1, prev_dat = 1'b1;
  logic [10:0] sh = '0;
  logic [7:0] rb;

  always @(negedge CLK) begin
    if (drop) drops++;
    if (!ps2_clk_out) chk("dat_stable_clk_low", ps2_dat_out, prev_dat);
    if (!in_frame) begin
      gap_cnt++;
      if (ps2_clk_out && !ps2_dat_out && prev_dat) begin
        in_frame = 1'b1; bitcnt = 0; flen = 1; hi_run = 1; starts++;
        gap_log.push_back(gap_cnt);
      end
    end else begin
      flen++;
      if (ps2_clk_out) hi_run++; else hi_run = 0;
      if (!ps2_clk_out && prev_clk && bitcnt < 11) begin
        sh[bitcnt] = ps2_dat_out; bitcnt++;
      end
      if (ps2_clk_out && !prev_clk && bitcnt == 11) begin
        rb = sh[8:1];
        frames++; in_frame = 1'b0; gap_cnt = 0;
        chk("frame_len", flen - 1, FLEN);
        chk("start_bit", sh[0], 1'b0);
        chk("stop_bit", sh[10], 1'b1);
        chk("parity_odd", sh[9], ~^rb);
        rx_byte.push_back(rb); rx_par.push_back(sh[9]);
        chk("byte_expected", expq.size() > 0, 1'b1);
        if (expq.size() > 0) chk("byte_value", rb, expq.pop_front());
      end else if (hi_run > HP) begin
        in_frame = 1'b0; aborts++; gap_cnt = 0;
      end
    end
    prev_clk = ps2_clk_out;
    prev_dat = ps2_dat_out;
  end

  task automatic toggle(input logic [23:0] pkt, input bit sent);
    @(negedge CLK);
    ps2_mouse = {~ps2_mouse[24], pkt};
    if (sent) begin
      expq.push_back(pkt[7:0]);
      expq.push_back(pkt[15:8]);
      expq.push_back(pkt[23:16]);
    end
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    do begin
      @(negedge CLK); #1; n++;
    end while ((busy || in_frame) && n < limit);
    chk({tag, "_idle_in_time"}, n < limit, 1'b1);
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: run exceeded 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, f0, d0, a0, s1, n;
    ps2_mouse = {1'b1, 24'h123456};
    RESET_N = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_clk_out", ps2_clk_out, 1'b1);
    chk("rst_dat_out", ps2_dat_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop, 1'b0);
    RESET_N = 1'b1;
    repeat (40) @(negedge CLK); #1;
    chk("no_pkt_on_release", starts, 0);
    chk("idle_busy", busy, 1'b0);

    // Basic packet 0x05_FE_08
    s0 = starts; f0 = frames;
    toggle(24'h05FE08, 1'b1);
    @(posedge CLK); #1;
    chk("busy_after_strobe", busy, 1'b1);
    wait_idle(600, "pkt1");
    chk("pkt1_frames", frames - f0, 3);
    if (frames - f0 == 3 && gap_log.size() >= s0 + 3) begin
      chk("pkt1_b0", rx_byte[f0], 8'h08);
      chk("pkt1_b1", rx_byte[f0 + 1], 8'hFE);
      chk("pkt1_b2", rx_byte[f0 + 2], 8'h05);
      chk("pkt1_par0", rx_par[f0], 0);
      chk("pkt1_par1", rx_par[f0 + 1], 0);
      chk("pkt1_par2", rx_par[f0 + 2], 1);
      chk("pkt1_gap1", gap_log[s0 + 1], GAPC);
      chk("pkt1_gap2", gap_log[s0 + 2], GAPC);
    end
    chk("pkt1_drained", expq.size(), 0);

    // Three toggles 10 cycles apart: second is overwritten by the third
    d0 = drops; f0 = frames;
    toggle(24'h332211, 1'b1);
    repeat (9) @(negedge CLK);
    toggle(24'h665544, 1'b0);
    repeat (9) @(negedge CLK);
    toggle(24'h998877, 1'b1);
    @(posedge CLK); #1;
    chk("drop_pulse", drop, 1'b1);
    @(posedge CLK); #1;
    chk("drop_one_cycle", drop, 1'b0);
    wait_idle(1200, "ovw");
    chk("ovw_drop_count", drops - d0, 1);
    chk("ovw_frames", frames - f0, 6);
    chk("ovw_drained", expq.size(), 0);

    // Strobe in the cycle the slot is consumed: no drop, both sent
    d0 = drops; f0 = frames;
    toggle(24'hA1B2C3, 1'b1);
    toggle(24'h0F1E2D, 1'b1);
    wait_idle(1200, "same_cyc");
    chk("same_cyc_drop", drops - d0, 0);
    chk("same_cyc_frames", frames - f0, 6);
    chk("same_cyc_drained", expq.size(), 0);

    // Reset during data bit 5 of byte 1
    f0 = frames; n = 0;
    toggle(24'h5A3C96, 1'b1);
    do begin
      @(negedge CLK); #1; n++;
    end while (!(frames == f0 + 1 && in_frame && bitcnt == 6) && n < 400);
    chk("rst_mid_reached", n < 400, 1'b1);
    expq.delete();
    RESET_N = 1'b0;
    @(posedge CLK); #1;
    chk("rst_mid_clk", ps2_clk_out, 1'b1);
    chk("rst_mid_dat", ps2_dat_out, 1'b1);
    chk("rst_mid_busy", busy, 1'b0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    s1 = starts;
    repeat (300) @(negedge CLK); #1;
    chk("rst_no_resume", starts - s1, 0);
    chk("rst_busy_after", busy, 1'b0);

`ifdef PS2_MOUSE_INHIBIT_EN
    // Host inhibit during bit 3 of byte 0
    a0 = aborts; f0 = frames; n = 0;
    toggle(24'hC35A7E, 1'b1);
    do begin
      @(negedge CLK); #1; n++;
    end while (!(frames == f0 && in_frame && bitcnt == 3) && n < 200);
    chk("inh_reached", n < 200, 1'b1);
    ps2_clk_in = 1'b0;
    repeat (20) @(negedge CLK);
    ps2_clk_in = 1'b1;
    s1 = starts; n = 0;
    do begin
      @(negedge CLK); #1; n++;
    end while (starts == s1 && n < 50);
    chk("inh_abort", aborts - a0, 1);
    chk("inh_restart_delay", n, GAPC);
    wait_idle(600, "inh");
    chk("inh_frames", frames - f0, 3);
    chk("inh_drained", expq.size(), 0);

    // No departure from IDLE while the host holds the clock low
    ps2_clk_in = 1'b0;
    s1 = starts;
    toggle(24'h13579B, 1'b1);
    repeat (30) @(negedge CLK); #1;
    chk("inh_idle_hold", starts - s1, 0);
    chk("inh_idle_busy", busy, 1'b1);
    ps2_clk_in = 1'b1;
    wait_idle(600, "inh_idle");
    chk("inh_idle_drained", expq.size(), 0);
`else
    // Clock input is ignored in the default build
    a0 = aborts; f0 = frames;
    ps2_clk_in = 1'b0;
    toggle(24'hC35A7E, 1'b1);
    wait_idle(600, "noinh");
    chk("noinh_abort", aborts - a0, 0);
    chk("noinh_frames", frames - f0, 3);
    chk("noinh_drained", expq.size(), 0);
    ps2_clk_in = 1'b1;
`endif

    // Randomized 100-packet run: one packet from idle plus one queued behind it
    d0 = drops; f0 = frames;
    for (int r = 0; r < 50; r++) begin
      toggle(24'($urandom), 1'b1);
      repeat ($urandom_range(250, 4)) @(negedge CLK);
      toggle(24'($urandom), 1'b1);
      wait_idle(1500, "rand");
    end
    chk("rand_frames", frames - f0, 300);
    chk("rand_drops", drops - d0, 0);
    chk("rand_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
